// File: rtl/voice_allocator_if.sv
// Key-scan inputs and voice/event outputs of the polyphony scheduler.
interface voice_allocator_if #(
  parameter int NUM_KEYS   = 36,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 6,
  parameter int VOICE_W    = 2
);
  logic                        en;
  logic [NUM_KEYS-1:0]         keys;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic                        evt_valid;
  logic                        evt_on;
  logic                        evt_steal;
  logic [VOICE_W-1:0]          evt_voice;
  logic [KEY_W-1:0]            evt_key;

  modport master (
    output en, keys,
    input  voice_active, voice_key, evt_valid, evt_on, evt_steal, evt_voice, evt_key
  );

  modport slave (
    input  en, keys,
    output voice_active, voice_key, evt_valid, evt_on, evt_steal, evt_voice, evt_key
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans one key per clock, assigns pressed keys to mixer voices,
// steals the oldest voice when all are busy and frees a voice when its key is released.
module voice_allocator #(
  parameter int NUM_KEYS   = 36,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 6,
  parameter int VOICE_W    = 2,
  parameter int AGE_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  voice_allocator_if.slave  bus
);

  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);

  logic [KEY_W-1:0]            scan_ptr_reg;
  logic [NUM_VOICES-1:0]       active_reg;
  logic [NUM_VOICES*KEY_W-1:0] key_reg;
  logic [AGE_W-1:0]            age_reg [NUM_VOICES];
  logic                        evt_valid_reg;
  logic                        evt_on_reg;
  logic                        evt_steal_reg;
  logic [VOICE_W-1:0]          evt_voice_reg;
  logic [KEY_W-1:0]            evt_key_reg;

  logic [NUM_VOICES-1:0] hit_vec;
  logic [AGE_W-1:0]      age_inc [NUM_VOICES];

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign hit_vec[gi] = active_reg[gi] && (key_reg[gi*KEY_W +: KEY_W] == scan_ptr_reg);
      assign age_inc[gi] = (age_reg[gi] == AGE_MAX) ? AGE_MAX : age_reg[gi] + AGE_W'(1);
    end
  endgenerate

  logic               pressed;
  logic               hit_any;
  logic               free_any;
  logic               note_on;
  logic               note_off;
  logic [VOICE_W-1:0] hit_idx;
  logic [VOICE_W-1:0] free_idx;
  logic [VOICE_W-1:0] old_idx;
  logic [AGE_W-1:0]   old_age;
  logic [VOICE_W-1:0] target;

  assign pressed = bus.keys[scan_ptr_reg];

  always_comb begin
    hit_any  = |hit_vec;
    free_any = ~&active_reg;
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = age_reg[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (hit_vec[v]) hit_idx = VOICE_W'(v);
    end
    // Descending walk leaves the lowest-index free voice selected.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active_reg[v]) free_idx = VOICE_W'(v);
    end
    // Strict compare keeps the lowest index on age ties.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_reg[v] > old_age) begin
        old_age = age_reg[v];
        old_idx = VOICE_W'(v);
      end
    end
    note_on  = bus.en && pressed && !hit_any;
    note_off = bus.en && !pressed && hit_any;
    target   = note_on ? (free_any ? free_idx : old_idx) : hit_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_ptr_reg  <= '0;
      active_reg    <= '0;
      key_reg       <= '0;
      evt_valid_reg <= 1'b0;
      evt_on_reg    <= 1'b0;
      evt_steal_reg <= 1'b0;
      evt_voice_reg <= '0;
      evt_key_reg   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) age_reg[v] <= '0;
    end else begin
      evt_valid_reg <= note_on || note_off;
      if (bus.en) begin
        scan_ptr_reg <= (scan_ptr_reg == LAST_KEY) ? '0 : scan_ptr_reg + KEY_W'(1);
        if (note_on || note_off) begin
          evt_on_reg    <= note_on;
          evt_steal_reg <= note_on && !free_any;
          evt_voice_reg <= target;
          evt_key_reg   <= scan_ptr_reg;
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (note_on) begin
            if (target == VOICE_W'(v)) begin
              active_reg[v]               <= 1'b1;
              key_reg[v*KEY_W +: KEY_W]   <= scan_ptr_reg;
              age_reg[v]                  <= '0;
            end else if (active_reg[v]) begin
              age_reg[v] <= age_inc[v];
            end
          end else if (note_off && target == VOICE_W'(v)) begin
            active_reg[v] <= 1'b0;
            age_reg[v]    <= '0;
          end
        end
      end
    end
  end

  assign bus.voice_active = active_reg;
  assign bus.voice_key    = key_reg;
  assign bus.evt_valid    = evt_valid_reg;
  assign bus.evt_on       = evt_on_reg;
  assign bus.evt_steal    = evt_steal_reg;
  assign bus.evt_voice    = evt_voice_reg;
  assign bus.evt_key      = evt_key_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a note-level reference model queues expected
// events; a negedge monitor pops and compares each event the DUT reports.
module tb_voice_allocator;
  localparam int NK   = 36;
  localparam int NV   = 4;
  localparam int KW   = 6;
  localparam int AMAX = 15;

  logic clk = 1'b0;
  logic rst;

  voice_allocator_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW), .VOICE_W(2)) bus ();

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW), .VOICE_W(2), .AGE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit on;
    bit steal;
    int voice;
    int key;
  } evt_t;

  evt_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: age is the number of note-ons since the voice was taken, capped.
  bit m_act   [NV];
  int m_key   [NV];
  int m_stamp [NV];
  int m_ptr;
  int m_on_cnt;

  function automatic int m_age(int v);
    int d;
    if (!m_act[v]) return 0;
    d = m_on_cnt - m_stamp[v];
    return (d > AMAX) ? AMAX : d;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_act[v]   = 1'b0;
      m_key[v]   = 0;
      m_stamp[v] = 0;
    end
    m_ptr    = 0;
    m_on_cnt = 0;
  endtask

  task automatic model_step();
    int   hit;
    int   v;
    bit   p;
    evt_t e;
    if (bus.en !== 1'b1) return;
    p   = bus.keys[m_ptr];
    hit = -1;
    for (int i = 0; i < NV; i++) if (m_act[i] && m_key[i] == m_ptr) hit = i;
    if (p && hit < 0) begin
      v = -1;
      for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) v = i;
      e.steal = (v < 0);
      if (v < 0) begin
        v = 0;
        for (int i = 1; i < NV; i++) if (m_age(i) > m_age(v)) v = i;
      end
      m_on_cnt++;
      m_stamp[v] = m_on_cnt;
      m_act[v]   = 1'b1;
      m_key[v]   = m_ptr;
      e.on = 1'b1; e.voice = v; e.key = m_ptr;
      sb.push_back(e);
    end else if (!p && hit >= 0) begin
      m_act[hit] = 1'b0;
      e.on = 1'b0; e.steal = 1'b0; e.voice = hit; e.key = m_ptr;
      sb.push_back(e);
    end
    m_ptr = (m_ptr + 1) % NK;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_state(input string tag);
    logic [NV-1:0]    ea;
    logic [NV*KW-1:0] ek;
    for (int v = 0; v < NV; v++) begin
      ea[v]          = m_act[v];
      ek[v*KW +: KW] = KW'(m_key[v]);
    end
    chk({tag, "_active"}, 64'(bus.voice_active), 64'(ea));
    chk({tag, "_key"},    64'(bus.voice_key),    64'(ek));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_active"}, 64'(bus.voice_active), 64'd0);
    chk({tag, "_key"},    64'(bus.voice_key),    64'd0);
    chk({tag, "_valid"},  64'(bus.evt_valid),    64'd0);
  endtask

  // Called near a negedge; the scanned key is latched at the following posedge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  always @(negedge clk) begin : monitor
    evt_t e;
    if (rst === 1'b1 && bus.evt_valid === 1'b1) begin
      $display("EVT t=%0t on=%0d steal=%0d voice=%0d key=%0d",
               $time, bus.evt_on, bus.evt_steal, bus.evt_voice, bus.evt_key);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL evt_unexpected: got on=%0d voice=%0d key=%0d want no event",
                 bus.evt_on, bus.evt_voice, bus.evt_key);
      end else begin
        e = sb.pop_front();
        chk("evt", 64'({bus.evt_on, bus.evt_steal, bus.evt_voice, bus.evt_key}),
            64'({1'(e.on), 1'(e.steal), 2'(e.voice), 6'(e.key)}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst      = 1'b0;
    bus.en   = 1'b0;
    bus.keys = '0;
    model_reset();
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single key 0 lands in voice 0.
    bus.en      = 1'b1;
    bus.keys[0] = 1'b1;
    run(2);
    check_state("t1");
    chk("t1_active_const", 64'(bus.voice_active), 64'h1);

    // Free voice 0, then four keys fill voices 0..3 in scan order.
    bus.keys = '0;
    run(36);
    bus.keys[3] = 1'b1; bus.keys[7] = 1'b1; bus.keys[9] = 1'b1; bus.keys[12] = 1'b1;
    run(36);
    check_state("t2");
    chk("t2_key_const", 64'(bus.voice_key), 64'({6'd12, 6'd9, 6'd7, 6'd3}));

    // Fifth key steals the oldest voice (voice 0).
    bus.keys[20] = 1'b1;
    run(19);
    check_state("t3");
    chk("t3_key0_const", 64'(bus.voice_key[5:0]), 64'd20);

    // Release 3 and 9: voice 2 frees, then key 25 reuses it.
    bus.keys[3] = 1'b0;
    bus.keys[9] = 1'b0;
    run(37);
    check_state("t4a");
    chk("t4_active_const", 64'(bus.voice_active), 64'hb);
    bus.keys[25] = 1'b1;
    run(36);
    check_state("t4b");
    chk("t4_key2_const", 64'(bus.voice_key[17:12]), 64'd25);

    // Frozen scan while keys move.
    bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idx = $urandom_range(0, NK - 1);
      bus.keys[idx] = ~bus.keys[idx];
      step();
    end
    check_state("t5");
    chk("t5_valid", 64'(bus.evt_valid), 64'd0);
    bus.en = 1'b1;
    run(40);
    check_state("t5b");

    // Two long-held voices saturate their ages; the steal must pick the lowest of the tie.
    bus.keys = '0;
    bus.keys[0] = 1'b1;
    bus.keys[1] = 1'b1;
    run(72);
    for (int i = 0; i < 18; i++) begin
      bus.keys[10] = 1'b1;
      run(36);
      bus.keys[10] = 1'b0;
      run(36);
    end
    bus.keys[10] = 1'b1; bus.keys[11] = 1'b1;
    run(36);
    bus.keys[13] = 1'b1;
    run(36);
    check_state("sat");

    // Reset mid-scan with key 35 held.
    bus.keys = '0;
    bus.keys[35] = 1'b1;
    run(72);
    while (m_ptr != 20) step();
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_zero("t6_rst");
    #1;
    rst = 1'b1;
    run(35);
    chk("t6_before", 64'(bus.voice_active), 64'd0);
    step();
    check_state("t6");
    chk("t6_key35", 64'({bus.voice_active, bus.voice_key[5:0]}), 64'({4'h1, 6'd35}));

    // Random key traffic with occasional scan stalls.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, NK - 1);
        bus.keys[idx] = ($urandom_range(0, 2) == 0);
      end
      bus.en = ($urandom_range(0, 15) != 0);
      step();
      if (i % 10 == 0) check_state("rnd");
    end

    bus.en = 1'b0;
    run(2);
    #1;
    check_state("final");
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
